// File: rtl/tsu_queue_drain.sv
// tsu_queue_drain: drains 56-bit timestamp entries from the tsu queue read port
// into a 2-entry buffer and presents them to the host over valid/ready.
// Latency: q_rd_en one cycle after the IDLE decision; capture RD_LAT edges after
//   the queue samples q_rd_en; ts_valid the cycle after capture.
// Backpressure: no read is issued while the buffer holds 2 entries; ts_valid
//   and ts_data are held until ts_ready.
//
// Ports:
//   q_rd_clk, rst_n     clock, async active-low reset
//   enable              0 = issue no new reads (an in-flight read still completes)
//   q_rd_stat           queue occupancy
//   q_rd_en/q_rd_data   queue read strobe and returned entry
//   ts_valid/ts_ready/ts_data  host-side handshake, ts_data is the buffer head
//   drain_cnt           entries pushed into the buffer since reset (wrapping)
//   busy                FSM in READ or WAIT
// Optional build macro TSU_DRAIN_FILTER_EN adds filt_mask (per msg-type keep
// mask) and drop_cnt (entries read but discarded by the mask).

module tsu_queue_drain #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             q_rd_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       q_rd_stat,
  output logic             q_rd_en,
  input  logic [55:0]      q_rd_data,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic [55:0]      ts_data,
  output logic [CNT_W-1:0] drain_cnt,
`ifdef TSU_DRAIN_FILTER_EN
  input  logic [15:0]      filt_mask,
  output logic [CNT_W-1:0] drop_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wait_cnt;
  logic [1:0]  buf_cnt;
  logic [55:0] head_q;
  logic [55:0] tail_q;
  logic        capture;
  logic        keep;
  logic        push;
  logic        pop;

  // State register. q_rd_en is registered from the next state so the strobe
  // is a clean flop output, high exactly for the READ cycle.
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      q_rd_en  <= 1'b0;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      q_rd_en  <= (state_nxt == READ);
      wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
    end
  end

  // Next-state logic. Buffer room is only checked here: with a single read in
  // flight, a capture can never land on a full buffer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable && (q_rd_stat != 8'd0) && (buf_cnt != 2'd2)) state_nxt = READ;
      READ: state_nxt = WAIT;
      WAIT: if (wait_cnt == WAIT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy    = (state != IDLE);
    capture = (state == WAIT) && (wait_cnt == WAIT_LAST);
  end

`ifdef TSU_DRAIN_FILTER_EN
  assign keep = filt_mask[q_rd_data[55:52]];
`else
  assign keep = 1'b1;
`endif

  assign pop      = (buf_cnt != 2'd0) && ts_ready;
  assign push     = capture && keep && (buf_cnt != 2'd2);
  assign ts_valid = (buf_cnt != 2'd0);
  assign ts_data  = head_q;

  // 2-entry buffer: head_q is always the oldest entry. On a pop with two
  // entries the tail shifts into the head; a simultaneous push refills tail.
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= 2'd0;
      head_q  <= 56'd0;
      tail_q  <= 56'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) head_q <= q_rd_data;
          else                 tail_q <= q_rd_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          if (buf_cnt == 2'd2) head_q <= tail_q;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            head_q <= q_rd_data;
          end else begin
            head_q <= tail_q;
            tail_q <= q_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n)    drain_cnt <= '0;
    else if (push) drain_cnt <= drain_cnt + 1'b1;
  end

`ifdef TSU_DRAIN_FILTER_EN
  // Filtered entries are still read out of the tsu queue, only counted here.
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n)                drop_cnt <= '0;
    else if (capture && !keep) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_tsu_queue_drain.sv
`timescale 1ns/1ps
module tb_tsu_queue_drain;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam logic [55:0] JUNK = 56'hEE_EEEE_0BAD_F00D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // lane 0: RD_LAT=1, CNT_W=4 ; lane 1: RD_LAT=3, CNT_W=16
  logic        enable   [2];
  logic [7:0]  stat     [2];
  logic        rd_en    [2];
  logic [55:0] rd_data  [2];
  logic        ts_valid [2];
  logic        ts_ready [2];
  logic [55:0] ts_data  [2];
  logic        busy     [2];
  logic [3:0]  dcnt0;
  logic [15:0] dcnt1;
`ifdef TSU_DRAIN_FILTER_EN
  logic [15:0] mask [2];
  logic [3:0]  drop0;
  logic [15:0] drop1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses [2];
  int outs [2];

  // queue model
  logic [55:0] qmem [2][64];
  int qhead [2];
  int qtail [2];
  logic [55:0] pipe [2][4];
  logic [55:0] sb0 [$];
  logic [55:0] sb1 [$];

  assign stat[0]    = 8'(qtail[0] - qhead[0]);
  assign stat[1]    = 8'(qtail[1] - qhead[1]);
  assign rd_data[0] = pipe[0][LAT0-1];
  assign rd_data[1] = pipe[1][LAT1-1];

  tsu_queue_drain #(.RD_LAT(LAT0), .CNT_W(4)) u_lat1 (
    .q_rd_clk(clk), .rst_n(rst_n), .enable(enable[0]), .q_rd_stat(stat[0]),
    .q_rd_en(rd_en[0]), .q_rd_data(rd_data[0]), .ts_valid(ts_valid[0]),
    .ts_ready(ts_ready[0]), .ts_data(ts_data[0]), .drain_cnt(dcnt0),
`ifdef TSU_DRAIN_FILTER_EN
    .filt_mask(mask[0]), .drop_cnt(drop0),
`endif
    .busy(busy[0]));

  tsu_queue_drain #(.RD_LAT(LAT1), .CNT_W(16)) u_lat3 (
    .q_rd_clk(clk), .rst_n(rst_n), .enable(enable[1]), .q_rd_stat(stat[1]),
    .q_rd_en(rd_en[1]), .q_rd_data(rd_data[1]), .ts_valid(ts_valid[1]),
    .ts_ready(ts_ready[1]), .ts_data(ts_data[1]), .drain_cnt(dcnt1),
`ifdef TSU_DRAIN_FILTER_EN
    .filt_mask(mask[1]), .drop_cnt(drop1),
`endif
    .busy(busy[1]));

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Queue read side: pops on a sampled q_rd_en, data appears RD_LAT cycles later.
  initial forever begin
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (rd_en[g] === 1'b1) begin
        checks++;
        if (qhead[g] == qtail[g]) begin
          errors++;
          $display("FAIL rd_on_empty lane%0d: read issued with stat=%0d, required stat>0", g, stat[g]);
        end
        pipe[g][0] <= qmem[g][qhead[g] % 64];
        qhead[g]   <= qhead[g] + 1;
      end else begin
        pipe[g][0] <= JUNK;
      end
      for (int i = 1; i < 4; i++) pipe[g][i] <= pipe[g][i-1];
    end
  end

  // Output monitor: scoreboard pop, strobe width, no-retraction.
  initial begin
    logic        prev_rd [2];
    logic        prev_v  [2];
    logic        prev_r  [2];
    logic [55:0] prev_d  [2];
    logic        prev_rst;
    logic [55:0] exp_d;
    bit          got;
    prev_rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      prev_rd[g] = 1'b0; prev_v[g] = 1'b0; prev_r[g] = 1'b0; prev_d[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rd_en[g] === 1'b1) begin
          checks++;
          if (prev_rd[g] === 1'b1) begin
            errors++;
            $display("FAIL rd_en_width lane%0d: high 2+ cycles, required 1", g);
          end else pulses[g]++;
        end
        if (prev_rst && rst_n && prev_v[g] && !prev_r[g]) begin
          checks++;
          if (ts_valid[g] !== 1'b1 || ts_data[g] !== prev_d[g]) begin
            errors++;
            $display("FAIL hold lane%0d: valid=%b data=%h, required valid=1 data=%h",
                     g, ts_valid[g], ts_data[g], prev_d[g]);
          end
        end
        if (rst_n && ts_valid[g] === 1'b1 && ts_ready[g] === 1'b1) begin
          got = 0;
          exp_d = '0;
          if (g == 0 && sb0.size() != 0) begin exp_d = sb0.pop_front(); got = 1; end
          if (g == 1 && sb1.size() != 0) begin exp_d = sb1.pop_front(); got = 1; end
          checks++;
          outs[g]++;
          if (!got) begin
            errors++;
            $display("FAIL sb_extra lane%0d: got %h, required no output", g, ts_data[g]);
          end else if (ts_data[g] !== exp_d) begin
            errors++;
            $display("FAIL sb_data lane%0d: got %h, required %h", g, ts_data[g], exp_d);
          end
        end
        prev_rd[g] = rd_en[g];
        prev_v[g]  = ts_valid[g];
        prev_r[g]  = ts_ready[g];
        prev_d[g]  = ts_data[g];
      end
      prev_rst = rst_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic push_entry(input int g, input logic [55:0] d);
    bit kept;
    qmem[g][qtail[g] % 64] = d;
    qtail[g] = qtail[g] + 1;
    kept = 1;
`ifdef TSU_DRAIN_FILTER_EN
    kept = mask[g][d[55:52]];
`endif
    if (kept) begin
      if (g == 0) sb0.push_back(d);
      else        sb1.push_back(d);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    enable[0] = 1'b0; enable[1] = 1'b0;
    qtail[0] = qhead[0]; qtail[1] = qhead[1];
    sb0.delete(); sb1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_rise(input int g, output bit ok);
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rd_en[g] === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_drain(input int g, output bit ok);
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (qhead[g] == qtail[g] && busy[g] === 1'b0 && ts_valid[g] === 1'b0 &&
          (g == 0 ? sb0.size() == 0 : sb1.size() == 0)) begin
        ok = 1; break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rd_en[g] !== 1'b0 || ts_valid[g] !== 1'b0 || busy[g] !== 1'b0 || ts_data[g] !== 56'd0) begin
        errors++;
        $display("FAIL reset_state lane%0d: rd_en=%b valid=%b busy=%b data=%h, required 0 0 0 0",
                 g, rd_en[g], ts_valid[g], busy[g], ts_data[g]);
      end
    end
    checks++;
    if (dcnt0 !== 4'd0 || dcnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: drain=%0d/%0d, required 0/0", dcnt0, dcnt1);
    end
    rst_n = 1'b1;
    // reset while the lane-0 read is in WAIT
    ts_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) push_entry(0, 56'h11_1111_0000_0000 + 56'(i));
    @(posedge clk); #1 enable[0] = 1'b1;
    wait_rise(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_rd_timeout: no q_rd_en, required one"); end
    @(posedge clk); #2;
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL reset_wait_busy: busy=%b, required 1", busy[0]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_en[0] !== 1'b0 || ts_valid[0] !== 1'b0 || dcnt0 !== 4'd0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rd_en=%b valid=%b drain=%0d busy=%b, required 0 0 0 0",
               rd_en[0], ts_valid[0], dcnt0, busy[0]);
    end
    enable[0] = 1'b0;
    qtail[0] = qhead[0];
    sb0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (ts_valid[0] !== 1'b0 || dcnt0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_no_capture: valid=%b drain=%0d, required 0 0", ts_valid[0], dcnt0);
    end
  endtask

  task automatic test_single();
    logic [55:0] d;
    int p0;
    bit ok;
    d = 56'hA5_1234_DEADBEEF;
    ts_ready[0] = 1'b1;
    p0 = pulses[0];
    push_entry(0, d);
    @(posedge clk); #1 enable[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd_en[0] !== 1'b1) begin errors++; $display("FAIL single_rd_e0: rd_en=%b, required 1", rd_en[0]); end
    @(posedge clk); #1;
    checks++;
    if (rd_en[0] !== 1'b0 || ts_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_e1: rd_en=%b valid=%b, required 0 0", rd_en[0], ts_valid[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (ts_valid[0] !== 1'b1 || ts_data[0] !== d || dcnt0 !== 4'd1) begin
      errors++;
      $display("FAIL single_e2: valid=%b data=%h drain=%0d, required 1 %h 1", ts_valid[0], ts_data[0], dcnt0, d);
    end
    wait_drain(0, ok);
    checks++;
    if (!ok || pulses[0] - p0 != 1) begin
      errors++;
      $display("FAIL single_pulses: drained=%b pulses=%0d, required 1 1", ok, pulses[0] - p0);
    end
  endtask

  task automatic test_backpressure();
    logic [55:0] first;
    logic [55:0] d;
    int p0;
    bit ok;
    ts_ready[0] = 1'b0;
    p0 = pulses[0];
    first = '0;
    for (int i = 0; i < 5; i++) begin
      d = {4'(i + 1), 4'h0, 16'(16'h0B00 + i), $urandom};
      if (i == 0) first = d;
      push_entry(0, d);
    end
    @(posedge clk); #1 enable[0] = 1'b1;
    repeat (25) @(negedge clk);
    checks++;
    if (pulses[0] - p0 != 2 || stat[0] !== 8'd3) begin
      errors++;
      $display("FAIL bp_reads: pulses=%0d stat=%0d, required 2 3", pulses[0] - p0, stat[0]);
    end
    checks++;
    if (ts_valid[0] !== 1'b1 || ts_data[0] !== first || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_head: valid=%b data=%h busy=%b, required 1 %h 0", ts_valid[0], ts_data[0], busy[0], first);
    end
    @(posedge clk); #1 ts_ready[0] = 1'b1;
    wait_drain(0, ok);
    checks++;
    if (!ok || pulses[0] - p0 != 5 || dcnt0 !== 4'd6) begin
      errors++;
      $display("FAIL bp_drain: drained=%b pulses=%0d drain=%0d, required 1 5 6", ok, pulses[0] - p0, dcnt0);
    end
  endtask

  task automatic test_latency();
    int c [4];
    int cv;
    bit ok;
    ts_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) push_entry(1, {4'(i), 4'h0, 16'(16'h0C00 + i), $urandom});
    @(posedge clk); #1 enable[1] = 1'b1;
    wait_rise(1, ok);
    c[0] = cyc;
    cv = -100;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ts_valid[1] === 1'b1) begin cv = cyc; break; end
    end
    checks++;
    if (!ok || cv - c[0] != LAT1 + 1) begin
      errors++;
      $display("FAIL lat_capture: valid %0d cycles after strobe, required %0d", cv - c[0], LAT1 + 1);
    end
    for (int i = 1; i < 4; i++) begin
      wait_rise(1, ok);
      c[i] = cyc;
      checks++;
      if (!ok || c[i] - c[i-1] != LAT1 + 2) begin
        errors++;
        $display("FAIL lat_spacing%0d: spacing=%0d, required %0d", i, c[i] - c[i-1], LAT1 + 2);
      end
    end
    wait_drain(1, ok);
    checks++;
    if (!ok || dcnt1 !== 16'd4 || outs[1] != 4) begin
      errors++;
      $display("FAIL lat_drain: drained=%b drain=%0d outs=%0d, required 1 4 4", ok, dcnt1, outs[1]);
    end
  endtask

  task automatic test_enable_wrap();
    int p0;
    bit ok;
    apply_reset();
    ts_ready[0] = 1'b1;
    p0 = pulses[0];
    for (int i = 0; i < 3; i++) push_entry(0, {4'(i + 2), 4'h0, 16'(16'h0D00 + i), $urandom});
    @(posedge clk); #1 enable[0] = 1'b1;
    wait_rise(0, ok);
    enable[0] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (!ok || pulses[0] - p0 != 1 || dcnt0 !== 4'd1 || stat[0] !== 8'd2 || sb0.size() != 2) begin
      errors++;
      $display("FAIL en_off: pulses=%0d drain=%0d stat=%0d pending=%0d, required 1 1 2 2",
               pulses[0] - p0, dcnt0, stat[0], sb0.size());
    end
    for (int i = 3; i < 17; i++) push_entry(0, {4'(i), 4'h0, 16'(16'h0D00 + i), $urandom});
    @(posedge clk); #1 enable[0] = 1'b1;
    wait_drain(0, ok);
    checks++;
    if (!ok || pulses[0] - p0 != 17 || dcnt0 !== 4'd1) begin
      errors++;
      $display("FAIL wrap: drained=%b pulses=%0d drain=%0d, required 1 17 1", ok, pulses[0] - p0, dcnt0);
    end
  endtask

`ifdef TSU_DRAIN_FILTER_EN
  task automatic test_filter();
    int p0;
    int o0;
    bit ok;
    mask[0] = 16'h0001;
    apply_reset();
    ts_ready[0] = 1'b1;
    p0 = pulses[0];
    o0 = outs[0];
    push_entry(0, 56'h00_0001_11111111);
    push_entry(0, 56'h30_0002_22222222);
    push_entry(0, 56'h00_0003_33333333);
    @(posedge clk); #1 enable[0] = 1'b1;
    wait_drain(0, ok);
    checks++;
    if (!ok || pulses[0] - p0 != 3 || outs[0] - o0 != 2 || drop0 !== 4'd1 || dcnt0 !== 4'd2) begin
      errors++;
      $display("FAIL filter: pulses=%0d outs=%0d drop=%0d drain=%0d, required 3 2 1 2",
               pulses[0] - p0, outs[0] - o0, drop0, dcnt0);
    end
    mask[0] = 16'hFFFF;
  endtask
`endif

  initial begin
    enable[0] = 1'b0; enable[1] = 1'b0;
    ts_ready[0] = 1'b0; ts_ready[1] = 1'b0;
    for (int g = 0; g < 2; g++) begin
      pulses[g] = 0; outs[g] = 0; qhead[g] = 0; qtail[g] = 0;
    end
`ifdef TSU_DRAIN_FILTER_EN
    mask[0] = 16'hFFFF; mask[1] = 16'hFFFF;
`endif
    test_reset();
    test_single();
    test_backpressure();
    test_latency();
    test_enable_wrap();
`ifdef TSU_DRAIN_FILTER_EN
    test_filter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
